leak_tick_sequencer: RTL and testbench

Per-tick controller for the neuron leak datapath. On each global tick it walks every neuron index and fetches that neuron's leak value and leak mode from the configuration memory. It applies the mode through an internal `leak_reversal_unit` instance and delivers one signed 8-bit leak per neuron to the neuron-update stage over a valid/ready handshake. It sits between the core configuration SRAM and the membrane-potential integrator.

---
 rtl/leak_ctrl_pkg.sv | 46 ++++
 rtl/leak_reversal_unit.sv | 28 ++
 rtl/leak_tick_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_leak_tick_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leak_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// leak_ctrl_pkg
// Shared definitions for the per-tick leak sequencer:
//   - LEAK_W        : width of a leak value (two's complement)
//   - leak_state_e  : sequencer FSM state encoding
//   - leak_mode_t   : 2-bit leak mode and its four named constants
//   - apply_leak_mode() : pure mode transform used by leak_reversal_unit
// No ports (package).
// -----------------------------------------------------------------------------
package leak_ctrl_pkg;

   localparam int LEAK_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } leak_state_e;

   typedef logic [1:0] leak_mode_t;

   localparam leak_mode_t LEAK_MODE_NORMAL = 2'b00;
   localparam leak_mode_t LEAK_MODE_INVERT = 2'b01;
   localparam leak_mode_t LEAK_MODE_ZERO   = 2'b10;
   localparam leak_mode_t LEAK_MODE_SIGN   = 2'b11;

   // Mode transform. Negation wraps at 8 bits, so 0x80 maps onto itself and
   // 0x00 stays 0x00; SIGN is an identity because the stored value already
   // carries its sign.
   function automatic logic [LEAK_W-1:0] apply_leak_mode(
      input logic [LEAK_W-1:0] leak,
      input leak_mode_t        mode
   );
      logic [LEAK_W-1:0] res;
      case (mode)
         LEAK_MODE_NORMAL: res = leak;
         LEAK_MODE_INVERT: res = (~leak) + {{(LEAK_W-1){1'b0}}, 1'b1};
         LEAK_MODE_ZERO:   res = '0;
         default:          res = leak;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/leak_reversal_unit.sv
// -----------------------------------------------------------------------------
// leak_reversal_unit
// Combinational leak-mode transform applied to one fetched leak value.
// Ports:
//   clk     in  1       present for drop-in compatibility; unused
//   rst     in  1       present for drop-in compatibility; unused
//   leak_i  in  LEAK_W  raw leak value from configuration memory
//   mode_i  in  2       leak mode (NORMAL / INVERT / ZERO / SIGN)
//   leak_o  out LEAK_W  transformed leak value
// -----------------------------------------------------------------------------
module leak_reversal_unit
   import leak_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LEAK_W-1:0] leak_i,
   input  leak_mode_t        mode_i,
   output logic [LEAK_W-1:0] leak_o
);

   // The unit is purely combinational; clock and reset are only kept so the
   // instance matches the existing port list.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign leak_o = apply_leak_mode(leak_i, mode_i);

endmodule

// File: rtl/leak_tick_sequencer.sv
// -----------------------------------------------------------------------------
// leak_tick_sequencer
// On every accepted global tick, sweeps neuron indices 0..NUM_NEURONS-1:
// reads each neuron's leak value/mode from configuration memory (1-cycle read
// latency), transforms it through leak_reversal_unit and presents one signed
// leak per neuron to the integrator over a valid/ready handshake.
//
// Build option: define LEAK_SKIP_ZERO_EN to drop mode-ZERO neurons from the
// output stream (no handshake, 2 cycles per such neuron). Default build emits
// 0x00 for them through the normal handshake.
//
// Parameters:
//   NUM_NEURONS  neurons per sweep (>= 2)
//   AW           index width, derived from NUM_NEURONS
// Ports:
//   clk         in  1       core clock, rising edge
//   rst         in  1       asynchronous reset, active low
//   tick_in     in  1       single-cycle global tick
//   cfg_rd_en   out 1       config read strobe
//   cfg_addr    out AW      config read address (neuron index)
//   cfg_leak    in  8       leak value, valid the cycle after cfg_rd_en
//   cfg_mode    in  2       leak mode, valid the cycle after cfg_rd_en
//   leak_valid  out 1       leak result available
//   leak_ready  in  1       integrator accepts result
//   leak_idx    out AW      neuron index of the presented result
//   leak_value  out 8       processed leak (two's complement)
//   busy        out 1       sweep in progress (state != IDLE)
//   tick_done   out 1       one-cycle pulse after the last neuron
//   overrun     out 1       one-cycle pulse for a tick seen while busy
// -----------------------------------------------------------------------------
module leak_tick_sequencer
   import leak_ctrl_pkg::*;
#(
   parameter  int NUM_NEURONS = 256,
   localparam int AW          = $clog2(NUM_NEURONS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_in,
   output logic              cfg_rd_en,
   output logic [AW-1:0]     cfg_addr,
   input  logic [LEAK_W-1:0] cfg_leak,
   input  leak_mode_t        cfg_mode,
   output logic              leak_valid,
   input  logic              leak_ready,
   output logic [AW-1:0]     leak_idx,
   output logic [LEAK_W-1:0] leak_value,
   output logic              busy,
   output logic              tick_done,
   output logic              overrun
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

   leak_state_e       state_q,      state_d;
   logic [AW-1:0]     idx_q,        idx_d;
   logic              cfg_rd_en_q,  cfg_rd_en_d;
   logic [AW-1:0]     cfg_addr_q,   cfg_addr_d;
   logic              leak_valid_q, leak_valid_d;
   logic [AW-1:0]     leak_idx_q,   leak_idx_d;
   logic [LEAK_W-1:0] leak_value_q, leak_value_d;
   logic              tick_done_q,  tick_done_d;
   logic              overrun_q,    overrun_d;

   logic [LEAK_W-1:0] rev_leak;
   logic [AW-1:0]     idx_inc;
   logic              idx_is_last;
   logic              skip_neuron;

   // cfg_leak/cfg_mode are only meaningful during LOAD; the FSM samples the
   // transformed value exactly in that cycle.
   leak_reversal_unit u_rev (
      .clk    (clk),
      .rst    (rst),
      .leak_i (cfg_leak),
      .mode_i (cfg_mode),
      .leak_o (rev_leak)
   );

   assign idx_inc     = idx_q + AW'(1);
   assign idx_is_last = (idx_q == LAST_IDX);

`ifdef LEAK_SKIP_ZERO_EN
   assign skip_neuron = (cfg_mode == LEAK_MODE_ZERO);
`else
   assign skip_neuron = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      leak_valid_d = leak_valid_q;
      leak_idx_d   = leak_idx_q;
      leak_value_d = leak_value_q;
      // A tick outside IDLE is dropped; it only raises a pulse next cycle.
      overrun_d    = tick_in && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (tick_in) begin
               state_d = ST_FETCH;
               idx_d   = '0;
            end
         end

         ST_FETCH: begin
            state_d = ST_LOAD;
         end

         ST_LOAD: begin
            if (skip_neuron) begin
               // Skipped neuron: move straight on without a handshake.
               if (idx_is_last) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_inc;
                  state_d = ST_FETCH;
               end
            end else begin
               leak_value_d = rev_leak;
               leak_idx_d   = idx_q;
               leak_valid_d = 1'b1;
               state_d      = ST_OUT;
            end
         end

         ST_OUT: begin
            // Outputs are held untouched until the integrator takes them.
            if (leak_valid_q && leak_ready) begin
               leak_valid_d = 1'b0;
               if (idx_is_last) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_inc;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end

         default: begin
            idx_d        = '0;
            leak_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase

      // Strobes are registered from the upcoming state so they line up with
      // the state they belong to, without combinational paths to the ports.
      cfg_rd_en_d = (state_d == ST_FETCH);
      cfg_addr_d  = cfg_rd_en_d ? idx_d : '0;
      tick_done_d = (state_d == ST_DONE);
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cfg_rd_en_q  <= 1'b0;
         cfg_addr_q   <= '0;
         leak_valid_q <= 1'b0;
         leak_idx_q   <= '0;
         leak_value_q <= '0;
         tick_done_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cfg_rd_en_q  <= cfg_rd_en_d;
         cfg_addr_q   <= cfg_addr_d;
         leak_valid_q <= leak_valid_d;
         leak_idx_q   <= leak_idx_d;
         leak_value_q <= leak_value_d;
         tick_done_q  <= tick_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign cfg_rd_en  = cfg_rd_en_q;
   assign cfg_addr   = cfg_addr_q;
   assign leak_valid = leak_valid_q;
   assign leak_idx   = leak_idx_q;
   assign leak_value = leak_value_q;
   assign tick_done  = tick_done_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_leak_tick_sequencer.sv
// -----------------------------------------------------------------------------
// tb_leak_tick_sequencer
// Self-checking bench for leak_tick_sequencer with NUM_NEURONS = 4. A
// timestamp-based reference model predicts every output each cycle; directed
// sweeps pin the model with hand-computed values, then randomized sweeps with
// random backpressure and stray ticks run against the model.
// Honors LEAK_SKIP_ZERO_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_leak_tick_sequencer;

   localparam int N  = 4;
   localparam int AW = $clog2(N);
`ifdef LEAK_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
   int plan_idx[$] = '{0, 1, 3};
   int plan_val[$] = '{5, 251, 128};
`else
   localparam bit SKIP = 1'b0;
   int plan_idx[$] = '{0, 1, 2, 3};
   int plan_val[$] = '{5, 251, 0, 128};
`endif
   localparam int PLAN_DONE_LAT = SKIP ? 12 : 13;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick_in = 1'b0;
   logic          leak_ready = 1'b0;
   logic          cfg_rd_en;
   logic [AW-1:0] cfg_addr;
   logic [7:0]    cfg_leak = '0;
   logic [1:0]    cfg_mode = '0;
   logic          leak_valid;
   logic [AW-1:0] leak_idx;
   logic [7:0]    leak_value;
   logic          busy, tick_done, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem_leak [N];
   logic [1:0] mem_mode [N];

   // model state: timestamps of the upcoming fetch / first-valid / done cycle
   int cyc = 0;
   bit m_active = 0;
   int m_idx = 0;
   int m_fetch = -100;
   int m_vfrom = -100;
   int m_done = -1;
   bit m_ovr = 0;

   // statistics gathered from the DUT for the directed checks
   int ovr_cnt, done_cnt, rd_cnt, first_valid_cyc, last_done_cyc, tick_cyc;
   int hs_idx[$];
   int hs_val[$];

   leak_tick_sequencer #(.NUM_NEURONS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .cfg_rd_en  (cfg_rd_en),
      .cfg_addr   (cfg_addr),
      .cfg_leak   (cfg_leak),
      .cfg_mode   (cfg_mode),
      .leak_valid (leak_valid),
      .leak_ready (leak_ready),
      .leak_idx   (leak_idx),
      .leak_value (leak_value),
      .busy       (busy),
      .tick_done  (tick_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // configuration memory: 1-cycle read latency, junk when not being read
   always @(posedge clk) begin
      if (cfg_rd_en) begin
         cfg_leak <= mem_leak[cfg_addr];
         cfg_mode <= mem_mode[cfg_addr];
      end else begin
         cfg_leak <= 8'($urandom);
         cfg_mode <= 2'($urandom);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   function automatic int ref_leak(input int v, input int m);
      case (m)
         0: return v;
         1: return (256 - v) % 256;
         2: return 0;
         default: return v;
      endcase
   endfunction

   function automatic bit rnd(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit exp_valid_now();
      return m_active && (m_done < 0) && (cyc >= m_vfrom);
   endfunction

   // sample at the falling edge: compare all outputs with the model
   task automatic cyc_begin();
      bit ev;
      @(negedge clk);
      ev = exp_valid_now();
      chk("busy", busy, m_active);
      chk("cfg_rd_en", cfg_rd_en, m_active && (cyc == m_fetch));
      if (m_active && (cyc == m_fetch))
         chk("cfg_addr", cfg_addr, m_idx);
      chk("leak_valid", leak_valid, ev);
      if (ev) begin
         chk("leak_idx", leak_idx, m_idx);
         chk("leak_value", leak_value, ref_leak(mem_leak[m_idx], mem_mode[m_idx]));
      end
      chk("tick_done", tick_done, m_active && (cyc == m_done));
      chk("overrun", overrun, m_ovr);
      if (overrun) ovr_cnt++;
      if (tick_done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (cfg_rd_en) rd_cnt++;
      if (leak_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
   endtask

   // drive this cycle's inputs, log the handshake, advance the model
   task automatic cyc_end(input bit t, input bit r);
      bit ev;
      bit ovr_next;
      tick_in    = t;
      leak_ready = r;
      if (leak_valid && r) begin
         hs_idx.push_back(int'(leak_idx));
         hs_val.push_back(int'(leak_value));
         $display("[TB] cycle %0d handshake idx=%0d leak=0x%02h", cyc, leak_idx, leak_value);
      end
      ev = exp_valid_now();
      ovr_next = 1'b0;
      if (!m_active) begin
         if (t) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_fetch  = cyc + 1;
            m_vfrom  = cyc + 3;
            m_done   = -1;
         end
      end else begin
         if (t) ovr_next = 1'b1;
         if (cyc == m_done) begin
            m_active = 1'b0;
         end else if ((ev && r) ||
                      (SKIP && (cyc == m_fetch + 1) && (mem_mode[m_idx] == 2'd2))) begin
            if (m_idx == N - 1) begin
               m_done = cyc + 1;
            end else begin
               m_idx++;
               m_fetch = cyc + 1;
               m_vfrom = cyc + 3;
            end
         end
      end
      m_ovr = ovr_next;
      cyc++;
   endtask

   task automatic clear_stats();
      ovr_cnt = 0;
      done_cnt = 0;
      rd_cnt = 0;
      first_valid_cyc = -1;
      last_done_cyc = -1;
      hs_idx.delete();
      hs_val.delete();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick_in = 1'b0;
      leak_ready = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cfg_rd_en", cfg_rd_en, 0);
      chk("rst_cfg_addr", cfg_addr, 0);
      chk("rst_leak_valid", leak_valid, 0);
      chk("rst_leak_idx", leak_idx, 0);
      chk("rst_leak_value", leak_value, 0);
      chk("rst_tick_done", tick_done, 0);
      chk("rst_overrun", overrun, 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      m_active = 1'b0;
      m_ovr = 1'b0;
      m_done = -1;
   endtask

   task automatic sweep(input int rdy_pct, input int xtick_pct);
      bit seen;
      int n;
      seen = 1'b0;
      n = 0;
      cyc_begin();
      tick_cyc = cyc;
      cyc_end(1'b1, rnd(rdy_pct));
      while (!seen && n < 600) begin
         cyc_begin();
         seen = tick_done;
         cyc_end(rnd(xtick_pct), rnd(rdy_pct));
         n++;
      end
      chk("sweep_completes", seen, 1);
   endtask

   task automatic check_seq(input string tag, input int ei[$], input int ev[$]);
      chk({tag, "_count"}, hs_val.size(), ev.size());
      for (int i = 0; i < ev.size(); i++) begin
         if (i < hs_val.size()) begin
            chk({tag, "_idx"}, hs_idx[i], ei[i]);
            chk({tag, "_val"}, hs_val[i], ev[i]);
         end
      end
   endtask

   task automatic load_plan();
      mem_leak[0] = 8'h05; mem_mode[0] = 2'b00;
      mem_leak[1] = 8'h05; mem_mode[1] = 2'b01;
      mem_leak[2] = 8'h7F; mem_mode[2] = 2'b10;
      mem_leak[3] = 8'h80; mem_mode[3] = 2'b11;
   endtask

   initial begin
      int q1_idx[$];
      int q1_val[$];
      bit seen;
      int stall;
      int n;
      bit r;

      load_plan();
      clear_stats();
      apply_reset();

      // 1: reference sweep with the plan configuration
      clear_stats();
      sweep(100, 0);
      chk("plan_first_valid_lat", first_valid_cyc - tick_cyc, 3);
      chk("plan_done_lat", last_done_cyc - tick_cyc, PLAN_DONE_LAT);
      check_seq("plan", plan_idx, plan_val);

      // 2: negate edge values
      mem_leak[0] = 8'h80; mem_leak[1] = 8'h00; mem_leak[2] = 8'h01; mem_leak[3] = 8'h7F;
      for (int i = 0; i < N; i++) mem_mode[i] = 2'b01;
      clear_stats();
      sweep(100, 0);
      check_seq("negate", '{0, 1, 2, 3}, '{128, 0, 255, 129});

      // 3: backpressure for 5 cycles on idx 1
      load_plan();
      clear_stats();
      stall = 0;
      seen = 1'b0;
      n = 0;
      cyc_begin();
      tick_cyc = cyc;
      cyc_end(1'b1, 1'b1);
      while (!seen && n < 200) begin
         cyc_begin();
         seen = tick_done;
         r = 1'b1;
         if (leak_valid && leak_idx == 1 && stall < 5) begin
            r = 1'b0;
            stall++;
         end
         cyc_end(1'b0, r);
         n++;
      end
      chk("bp_done_seen", seen, 1);
      chk("bp_stall_cycles", stall, 5);
      chk("bp_done_lat", last_done_cyc - tick_cyc, PLAN_DONE_LAT + 5);
      check_seq("bp", plan_idx, plan_val);

      // 4: ticks right after acceptance and during DONE
      clear_stats();
      seen = 1'b0;
      n = 0;
      cyc_begin();
      cyc_end(1'b1, 1'b1);
      cyc_begin();
      cyc_end(1'b1, 1'b1);
      while (!seen && n < 200) begin
         cyc_begin();
         seen = tick_done;
         cyc_end(seen, 1'b1);
         n++;
      end
      rd_cnt = 0;
      repeat (8) begin
         cyc_begin();
         cyc_end(1'b0, 1'b1);
      end
      chk("ovr_pulses", ovr_cnt, 2);
      chk("ovr_done_pulses", done_cnt, 1);
      chk("ovr_no_second_sweep", rd_cnt, 0);

      // 5: asynchronous reset while idx 2 is being presented
      mem_mode[2] = 2'b00;
      clear_stats();
      seen = 1'b0;
      n = 0;
      cyc_begin();
      cyc_end(1'b1, 1'b1);
      while (!seen && n < 200) begin
         cyc_begin();
         seen = leak_valid && (leak_idx == 2);
         cyc_end(1'b0, !seen);
         n++;
      end
      chk("rst_reached_idx2", seen, 1);
      apply_reset();
      load_plan();
      clear_stats();
      sweep(100, 0);
      check_seq("restart", plan_idx, plan_val);

      // 6: back-to-back ticks, second in the IDLE cycle after tick_done
      clear_stats();
      sweep(100, 0);
      q1_idx = hs_idx;
      q1_val = hs_val;
      hs_idx.delete();
      hs_val.delete();
      sweep(100, 0);
      chk("b2b_overrun", ovr_cnt, 0);
      chk("b2b_done_pulses", done_cnt, 2);
      check_seq("b2b", q1_idx, q1_val);
      check_seq("b2b_plan", plan_idx, plan_val);

      // 7: randomized sweeps against the model
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < N; i++) begin
            mem_leak[i] = 8'($urandom);
            mem_mode[i] = 2'($urandom);
         end
         sweep($urandom_range(30, 100), $urandom_range(0, 10));
         repeat ($urandom_range(0, 3)) begin
            cyc_begin();
            cyc_end(1'b0, rnd(50));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
